aes_dec_round_ctrl: RTL and testbench
=====================================

AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, giving the round count; 10 (AES-128) is the only supported value.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a ciphertext block is offered on in_data.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a ciphertext this cycle.
REQ-006 The block SHALL have port in_data, input, 128 bits: ciphertext, column-major, byte 0 in [127:120].
REQ-007 The block SHALL have port key_sel, output, 4 bits: index (0..10) of the round key requested from the external key store.
REQ-008 The block SHALL have port round_key, input, 128 bits: round key for key_sel, valid combinationally in the same cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: plaintext is available on out_data.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-011 The block SHALL have port out_data, output, 128 bits: plaintext, same byte order as in_data.
REQ-012 The block SHALL have port busy, output, 1 bit: high in ROUND and DONE.

Function
REQ-013 The block SHALL be an FSM with states IDLE, ROUND and DONE, a 128-bit state register st, and a 4-bit round counter rnd.
REQ-014 In IDLE the block SHALL drive in_ready=1 and key_sel=10; in ROUND and DONE it SHALL drive in_ready=0.
REQ-015 On an IDLE cycle with in_valid=1, the block SHALL load st <= in_data XOR round_key (the initial AddRoundKey) and rnd <= 9, and SHALL go to ROUND.
REQ-016 In ROUND the block SHALL drive key_sel=rnd and compute one round per cycle, in order: InvShiftRows, InvSubBytes, XOR round_key, then InvMixColumns only when rnd!=0; the result SHALL load into st.
REQ-017 InvShiftRows SHALL rotate row r right by r byte positions; InvSubBytes SHALL use the FIPS-197 inverse S-box; InvMixColumns SHALL use the GF(2^8) matrix {0e,0b,0d,09} with polynomial 0x11B.
REQ-018 In ROUND, when rnd!=0 the block SHALL decrement rnd by 1; when rnd==0 it SHALL go to DONE and leave rnd unchanged (no wrap to 15).
REQ-019 In DONE the block SHALL drive out_valid=1, out_data=st and key_sel=10, and SHALL hold out_data stable until the transfer completes.
REQ-020 In DONE with out_ready=1 the block SHALL go to IDLE; in_ready SHALL rise in the next cycle, never in the same cycle as the transfer.
REQ-021 Latency: if the block accepts in_data at edge E, out_valid SHALL first be high in the cycle after edge E+10 (10 ROUND cycles), giving a throughput of at most one block per 12 cycles.
REQ-022 The block SHALL ignore in_valid in ROUND and DONE; in_data is sampled only on the accept edge.
REQ-023 The block SHALL ignore out_ready outside DONE.
REQ-024 In states other than DONE, out_valid SHALL be 0 and out_data SHALL equal st.

Reset
REQ-025 With reset=1 at a rising edge, the block SHALL set state=IDLE, st=0 and rnd=0; after that edge it SHALL drive in_ready=1, out_valid=0, out_data=0, busy=0 and key_sel=10.
REQ-026 Reset SHALL take priority over every other transition, including mid-ROUND and DONE with out_ready=1, and the in-flight block SHALL be discarded with no output.

Verification
REQ-027 FIPS-197 C.1: round_key from expansion of 000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, out_valid 11 cycles after the accept cycle.
REQ-028 Key-select trace for the REQ-027 stimulus: key_sel sequence 10 (accept), 9,8,...,0 (ROUND cycles), 10 (DONE) -> exactly 10 ROUND cycles, with no InvMixColumns applied on rnd=0.
REQ-029 Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and changing in_data throughout -> out_valid and out_data held constant, in_ready=0, and no new block accepted.
REQ-030 Back-to-back: in_valid held at 1 with out_ready=1 -> second block accepted 1 cycle after the first transfer, and both plaintexts correct.
REQ-031 Reset during ROUND at rnd=4 -> next cycle IDLE with in_ready=1, out_valid=0 and out_data=0; the following block decrypts correctly.
REQ-032 All-zero in_data with all-zero round keys -> out_data equals the reference-model value (InvSubBytes(0)=0x52 propagated), which checks the S-box path.

Source files
------------

// File: rtl/aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_round_ctrl
// Purpose  : Iterative AES-128 decryption core. One inverse round per clock,
//            with the round keys fetched from an external key store through
//            key_sel / round_key.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            in_valid/in_ready - ciphertext handshake, in_data (128 bit)
//            key_sel           - round-key index requested from key store
//            round_key         - round key for key_sel, same-cycle
//            out_valid/out_ready - plaintext handshake, out_data (128 bit)
//            busy              - a block is being decrypted or presented
// Revision : 1.0 - initial release
// ============================================================================
module aes_dec_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_sel,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_round = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    // The last round key is also the one needed for the initial AddRoundKey,
    // so it is requested whenever no round is in progress.
    localparam logic [3:0] c_last_key  = 4'(NUM_ROUNDS);
    localparam logic [3:0] c_first_rnd = 4'(NUM_ROUNDS - 1);

    localparam logic [7:0] c_inv_sbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the {0e,0b,0d,09} circulant matrix; row 0 in [31:24].
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then optional InvMixColumns.
    // Byte (col c, row r) sits at index 4*c+r; row r rotates right by r, so
    // the destination column c takes its byte from column (c - r) mod 4.
    function automatic logic [127:0] inv_round(input logic [127:0] st,
                                               input logic [127:0] key,
                                               input logic         mix);
        logic [127:0] sr;
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = c_inv_sbox[st[127-8*(4*((c+4-r)%4)+r) -: 8]];
            end
        end
        res = sr ^ key;
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                res[127-32*c -: 32] = inv_mix_col(res[127-32*c -: 32]);
            end
        end
        return res;
    endfunction

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [127:0] r_st;
    logic [127:0] w_st_nxt;
    logic [3:0]   r_rnd;
    logic [3:0]   w_rnd_nxt;
    logic [127:0] w_round_out;

    // The final round (rnd == 0) omits InvMixColumns.
    assign w_round_out = inv_round(r_st, round_key, r_rnd != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_st    <= '0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_rnd_nxt   = r_rnd;
        case (r_state)
            c_idle: begin
                if (in_valid) begin
                    w_st_nxt    = in_data ^ round_key;
                    w_rnd_nxt   = c_first_rnd;
                    w_state_nxt = c_round;
                end
            end
            c_round: begin
                w_st_nxt = w_round_out;
                if (r_rnd == 4'd0) begin
                    w_state_nxt = c_done;
                end else begin
                    w_rnd_nxt = r_rnd - 4'd1;
                end
            end
            c_done: begin
                if (out_ready) begin
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign busy      = (r_state == c_round) || (r_state == c_done);
    assign key_sel   = (r_state == c_round) ? r_rnd : c_last_key;
    assign out_data  = r_st;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_dec_round_ctrl
// Purpose  : Self-checking bench for aes_dec_round_ctrl. Plaintexts are
//            encrypted by a byte-level AES model (S-box derived from the
//            GF(2^8) inverse and affine map), fed to the DUT as ciphertext,
//            and the returned plaintext, timing and key_sel trace are checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_dec_round_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_sel;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk [0:10];
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    int           n_chk  = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    // External key store: combinational lookup.
    assign round_key = (key_sel <= 4'd10) ? rk[key_sel] : 128'd0;

    aes_dec_round_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_sel   (key_sel),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'd0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] x, inv, s, rot;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'd0;
            if (x != 8'd0) begin
                inv = 8'd1;
                for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            end
            s   = inv;
            rot = inv;
            for (int k = 0; k < 4; k++) begin
                rot = {rot[6:0], rot[7]};
                s ^= rot;
            end
            s ^= 8'h63;
            sb[v]  = s;
            isb[s] = x;
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isb[v[127-8*i -: 8]] : sb[v[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = v[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'd0;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(m[(j + 4 - r) % 4], v[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] s;
        s = p ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r < 10) s = mix_cols(s, 1'b0);
            s ^= rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] c);
        logic [127:0] s;
        s = c ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r];
            if (r > 0) s = mix_cols(s, 1'b1);
        end
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'd0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- transaction ----------------
    // Offers ct, checks the key_sel trace and latency, holds out_ready low for
    // 'hold' DONE cycles while in_valid toggles in noise, then completes.
    task automatic xfer(input string tag, input logic [127:0] ct, input logic [127:0] pt, input int hold);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, ":in_ready_idle"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_data  = ct;
        check({tag, ":key_sel_accept"}, 128'(key_sel), 128'd10);
        @(posedge clk); #1;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            if (cnt < 10) check({tag, ":key_sel_round"}, 128'(key_sel), 128'(9 - cnt));
            in_valid  = 1'($urandom);
            in_data   = rand128();
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, ":latency"}, 128'(cnt), 128'd10);
        check({tag, ":out_data"}, out_data, pt);
        check({tag, ":key_sel_done"}, 128'(key_sel), 128'd10);
        check({tag, ":in_ready_done"}, 128'(in_ready), 128'd0);
        check({tag, ":busy_done"}, 128'(busy), 128'd1);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = rand128();
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, 128'(out_valid), 128'd1);
            check({tag, ":hold_data"}, out_data, pt);
            check({tag, ":hold_in_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand128();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ":post_valid"}, 128'(out_valid), 128'd0);
        check({tag, ":post_in_ready"}, 128'(in_ready), 128'd1);
        check({tag, ":post_busy"}, 128'(busy), 128'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ":in_ready"}, 128'(in_ready), 128'd1);
        check({tag, ":out_valid"}, 128'(out_valid), 128'd0);
        check({tag, ":out_data"}, out_data, 128'd0);
        check({tag, ":busy"}, 128'(busy), 128'd0);
        check({tag, ":key_sel"}, 128'(key_sel), 128'd10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] p, c;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        for (int k = 0; k < 11; k++) rk[k] = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // Known-answer vector, with 5 cycles of backpressure in DONE.
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        xfer("fips", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             128'h00112233445566778899aabbccddeeff, 5);

        // Back-to-back random blocks: expanded keys and arbitrary key sets.
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) expand_key(rand128());
            else for (int k = 0; k < 11; k++) rk[k] = rand128();
            p = rand128();
            c = encrypt(p);
            xfer($sformatf("rand%0d", t), c, p, int'($urandom_range(0, 3)));
        end

        // All-zero keys and data exercise the S-box path.
        for (int k = 0; k < 11; k++) rk[k] = '0;
        xfer("zero", 128'd0, decrypt(128'd0), 0);

        // Reset while rnd == 4, then a clean block.
        expand_key(rand128());
        p = rand128();
        c = encrypt(p);
        in_valid = 1'b1;
        in_data  = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        check("midrst:key_sel_before", 128'(key_sel), 128'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("midrst");
        xfer("after_rst", c, p, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
